hbm_latency_delay: RTL and testbench

Fixed-latency request/response delay buffer for the compute tile array memory model. It sits directly downstream of the NoC endpoint that serves an HBM channel. It accepts one payload beat per handshake, holds it for exactly `Latency` cycles, then presents it in order on a valid/ready output. The HBM response generator consumes it. The block models HBM access latency (default 100 cycles) with bounded outstanding capacity and correct back-pressure.

---
 rtl/hbm_latency_delay.sv | 101 ++++++++++
 tb/tb_hbm_latency_delay.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_latency_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hbm_latency_delay                                                          |
// | Fixed-latency, in-order delay FIFO modelling HBM access latency.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module hbm_latency_delay #(
  parameter int Latency   = 100,
  parameter int Depth     = 128,
  parameter int DataWidth = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DataWidth-1:0]     in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DataWidth-1:0]     out_data_o,
  output logic [$clog2(Depth):0]   outstanding_o
);

  localparam int c_addr_w = $clog2(Depth);
  localparam int c_cnt_w  = (Latency > 1) ? $clog2(Latency) : 1;

  localparam logic [c_cnt_w-1:0]  c_load    = c_cnt_w'(Latency - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
  localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);
  localparam logic [c_addr_w:0]   c_occ_one = (c_addr_w + 1)'(1);
  localparam logic [c_addr_w:0]   c_depth   = (c_addr_w + 1)'(Depth);

  logic [DataWidth-1:0] data_q [Depth];
  logic [c_cnt_w-1:0]   cnt_q  [Depth];
  logic [Depth-1:0]     vld_q;
  logic [c_addr_w-1:0]  wr_ptr_q;
  logic [c_addr_w-1:0]  rd_ptr_q;
  logic [c_addr_w:0]    occ_q;
  logic [c_addr_w:0]    occ_d;
  logic                 rdy_q;

  logic w_push;
  logic w_pop;

  assign w_push = in_valid_i && rdy_q;
  assign w_pop  = out_valid_o && out_ready_i;

  // Only head maturity gates the output, which keeps strict FIFO order.
  assign out_valid_o   = (occ_q != '0) && (cnt_q[rd_ptr_q] == '0);
  assign out_data_o    = data_q[rd_ptr_q];
  assign in_ready_o    = rdy_q;
  assign outstanding_o = occ_q;

  always_comb begin
    occ_d = occ_q;
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + c_occ_one;
      2'b01:   occ_d = occ_q - c_occ_one;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rdy_q    <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      // Counters saturate at zero so a stalled head never wraps back to immature.
      for (int i = 0; i < Depth; i++) begin
        if (vld_q[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - c_cnt_one;
        end
      end

      if (w_pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + c_ptr_one;
      end

      // A push never targets the head slot being popped: pushes are refused when full.
      if (w_push) begin
        data_q[wr_ptr_q] <= in_data_i;
        cnt_q[wr_ptr_q]  <= c_load;
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + c_ptr_one;
      end

      occ_q <= occ_d;
      // Registered ready: a pop while full frees space only for the following cycle.
      rdy_q <= (occ_d < c_depth);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hbm_latency_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hbm_latency_delay                                                       |
// | Directed self-checking bench for hbm_latency_delay (three configurations). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_hbm_latency_delay;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // A: Latency=100, Depth=128, DataWidth=64
  logic        a_vin, a_rdy, a_vout, a_ordy;
  logic [63:0] a_din, a_dout;
  logic [7:0]  a_occ;
  // B: Latency=4, Depth=4, DataWidth=16
  logic        b_vin, b_rdy, b_vout, b_ordy;
  logic [15:0] b_din, b_dout;
  logic [2:0]  b_occ;
  // C: Latency=1, Depth=4, DataWidth=16
  logic        c_vin, c_rdy, c_vout, c_ordy;
  logic [15:0] c_din, c_dout;
  logic [2:0]  c_occ;

  hbm_latency_delay #(.Latency(100), .Depth(128), .DataWidth(64)) u_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_vin), .in_ready_o(a_rdy), .in_data_i(a_din),
    .out_valid_o(a_vout), .out_ready_i(a_ordy), .out_data_o(a_dout),
    .outstanding_o(a_occ)
  );

  hbm_latency_delay #(.Latency(4), .Depth(4), .DataWidth(16)) u_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_vin), .in_ready_o(b_rdy), .in_data_i(b_din),
    .out_valid_o(b_vout), .out_ready_i(b_ordy), .out_data_o(b_dout),
    .outstanding_o(b_occ)
  );

  hbm_latency_delay #(.Latency(1), .Depth(4), .DataWidth(16)) u_c (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(c_vin), .in_ready_o(c_rdy), .in_data_i(c_din),
    .out_valid_o(c_vout), .out_ready_i(c_ordy), .out_data_o(c_dout),
    .outstanding_o(c_occ)
  );

  logic [15:0] q[$];
  logic        exp_rdy;
  logic        exp_vld;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Each loop iteration waits for the negedge of a cycle, checks that cycle's
  // outputs, then drives the inputs sampled at the edge ending that cycle.
  initial begin
    rst = 1'b1;
    a_vin = 1'b0; a_din = '0; a_ordy = 1'b1;
    b_vin = 1'b0; b_din = '0; b_ordy = 1'b1;
    c_vin = 1'b0; c_din = '0; c_ordy = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_a_ready", a_rdy, 0);
    check("rst_a_valid", a_vout, 0);
    check("rst_a_occ",   a_occ, 0);
    check("rst_a_data",  a_dout, 0);
    check("rst_b_ready", b_rdy, 0);
    check("rst_c_ready", c_rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_a_ready", a_rdy, 1);
    check("post_rst_b_ready", b_rdy, 1);
    check("post_rst_c_ready", c_rdy, 1);

    // Single beat, Latency=100
    a_vin = 1'b1; a_din = 64'hA5;
    for (int t = 1; t <= 101; t++) begin
      @(negedge clk);
      a_vin = 1'b0;
      check("t1_valid", a_vout, (t == 100) ? 1 : 0);
      check("t1_occ",   a_occ,  (t <= 100) ? 1 : 0);
      if (t == 100) check("t1_data", a_dout, 64'hA5);
    end

    // Streaming 500 beats, Latency=100, Depth=128
    for (int j = 0; j < 620; j++) begin
      @(negedge clk);
      if (j < 500) check("t2_in_ready", a_rdy, 1);
      check("t2_valid", a_vout, (j >= 100 && j < 600) ? 1 : 0);
      if (j >= 100 && j < 600) check("t2_data", a_dout, 64'(j - 100));
      if (j == 300) check("t2_occ", a_occ, 100);
      a_vin = (j < 500);
      a_din = 64'(j);
    end

    // Back-pressure saturation, Latency=4, Depth=4: ready drops every 5th cycle
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      exp_rdy = !(j >= 4 && (j % 5) == 4);
      exp_vld = (j >= 4) && !(j >= 8 && (j % 5) == 3);
      check("t3_in_ready", b_rdy, exp_rdy);
      check("t3_valid", b_vout, exp_vld);
      if (exp_vld) begin
        check("t3_data", b_dout, q[0]);
        void'(q.pop_front());
      end
      if (exp_rdy) q.push_back(16'(j + 'h100));
      b_vin = 1'b1;
      b_din = 16'(j + 'h100);
    end
    for (int h = 0; h < 20; h++) begin
      @(negedge clk);
      check("t3_hold_ready", b_rdy, (h == 0) ? 1 : 0);
      check("t3_hold_valid", b_vout, 1);
      check("t3_hold_data",  b_dout, q[0]);
      if (h >= 1) check("t3_hold_occ", b_occ, 4);
      if (h == 0) q.push_back(16'(20 + 'h100));
      b_vin  = 1'b1;
      b_din  = 16'(20 + h + 'h100);
      b_ordy = 1'b0;
    end
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      if (r < 4) begin
        check("t3_drain_valid", b_vout, 1);
        check("t3_drain_data",  b_dout, q[0]);
        void'(q.pop_front());
      end else begin
        check("t3_drain_done_valid", b_vout, 0);
        check("t3_drain_done_occ",   b_occ, 0);
      end
      b_vin  = 1'b0;
      b_ordy = 1'b1;
    end

    // Simultaneous push/pop at full, Depth=4
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_vin = 1'b1; b_ordy = 1'b0; b_din = 16'(16'h10 + k);
    end
    @(negedge clk);
    b_vin = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_full_occ",   b_occ, 4);
    check("t4_full_ready", b_rdy, 0);
    check("t4_full_valid", b_vout, 1);
    check("t4_full_data",  b_dout, 16'h10);
    b_vin = 1'b1; b_din = 16'h20; b_ordy = 1'b1;
    @(negedge clk);
    check("t4_after_pop_occ",   b_occ, 3);
    check("t4_after_pop_ready", b_rdy, 1);
    check("t4_after_pop_data",  b_dout, 16'h11);
    b_vin = 1'b1; b_din = 16'h21; b_ordy = 1'b1;
    @(negedge clk);
    check("t4_pushpop_occ",  b_occ, 3);
    check("t4_pushpop_data", b_dout, 16'h12);
    b_vin = 1'b0;
    @(negedge clk);
    check("t4_d3_data", b_dout, 16'h13);
    check("t4_d3_valid", b_vout, 1);
    @(negedge clk);
    check("t4_gap_valid", b_vout, 0);
    @(negedge clk);
    check("t4_late_valid", b_vout, 1);
    check("t4_late_data",  b_dout, 16'h21);
    @(negedge clk);
    check("t4_empty_occ", b_occ, 0);

    // Latency=1 back-to-back
    @(negedge clk);
    check("t5_idle_valid", c_vout, 0);
    c_vin = 1'b1; c_din = 16'h1;
    @(negedge clk);
    check("t5_v1_valid", c_vout, 1);
    check("t5_v1_data",  c_dout, 16'h1);
    c_vin = 1'b1; c_din = 16'h2;
    @(negedge clk);
    check("t5_v2_valid", c_vout, 1);
    check("t5_v2_data",  c_dout, 16'h2);
    c_vin = 1'b0;
    @(negedge clk);
    check("t5_end_valid", c_vout, 0);
    check("t5_end_occ",   c_occ, 0);

    // Reset mid-flight with 50 entries outstanding
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      a_vin = 1'b1; a_din = 64'(k + 1000);
    end
    @(negedge clk);
    a_vin = 1'b0;
    check("t6_occ50",   a_occ, 50);
    check("t6_pre_vld", a_vout, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", a_rdy, 0);
    check("t6_rst_valid", a_vout, 0);
    check("t6_rst_occ",   a_occ, 0);
    check("t6_rst_data",  a_dout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rel_ready", a_rdy, 1);
    check("t6_rel_valid", a_vout, 0);
    a_vin = 1'b1; a_din = 64'h77;
    for (int t = 1; t <= 101; t++) begin
      @(negedge clk);
      a_vin = 1'b0;
      check("t6_valid", a_vout, (t == 100) ? 1 : 0);
      if (t == 100) check("t6_data", a_dout, 64'h77);
    end
    check("t6_end_occ", a_occ, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
